// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor.
//   - Saturating-counter constants and step function, generic up to MAX_CTR_BITS.
//   - History fold: XOR of consecutive idx_w-bit slices of the history.
package bp_pkg;

    localparam int unsigned MAX_HIST     = 64;  // widest supported global history
    localparam int unsigned MAX_IDX_W    = 12;  // clog2(4096)
    localparam int unsigned MAX_CTR_BITS = 4;

    typedef logic [MAX_CTR_BITS-1:0] ctr_t;

    // Strongest-taken value of a counter of the given width.
    function automatic ctr_t ctr_max(input int unsigned bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    // Weakly not-taken value of a counter of the given width.
    function automatic ctr_t ctr_init(input int unsigned bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    // One saturating step towards the resolved outcome.
    function automatic ctr_t ctr_step(input ctr_t ctr, input logic taken,
                                      input int unsigned bits);
        if (taken) begin
            return (ctr == ctr_max(bits)) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    // Bits above the real history length must be zero, so the last slice is
    // implicitly zero-extended. idx_w >= 2, hence MAX_HIST/2 slices suffice.
    function automatic logic [MAX_IDX_W-1:0] fold_hist(input logic [MAX_HIST-1:0] hist,
                                                       input int unsigned idx_w);
        logic [MAX_HIST-1:0]  rest;
        logic [MAX_IDX_W-1:0] mask;
        logic [MAX_IDX_W-1:0] res;
        rest = hist;
        mask = ~({MAX_IDX_W{1'b1}} << idx_w);
        res  = '0;
        for (int s = 0; s < MAX_HIST / 2; s++) begin
            res  = res ^ (rest[MAX_IDX_W-1:0] & mask);
            rest = rest >> idx_w;
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_hist_chain.sv
// Combinational lane history chain for the gshare predictor.
// Walks the fetch lanes in order, forming each lane's history and table index,
// producing the per-lane prediction and selecting the next global history.
// Ports:
//   ghr_i          current global history
//   fetch_valid_i  bundle accepted this cycle
//   lane_valid_i   per-lane valid (contiguous from lane 0)
//   pc_i           per-lane PC
//   is_branch_i    per-lane conditional-branch flag
//   ctr_msb_i      MSB of every pattern-table counter
//   recover_i      a resolve port requests history recovery
//   recover_ghr_i  history to restore on recovery
//   taken_o        per-lane prediction
//   ghist_o        per-lane {history used, prediction}
//   ghr_d_o        next global history
module gshare_hist_chain
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES     = 64,
    parameter int unsigned FETCH_WIDTH = 5,
    parameter int unsigned HIST_LEN    = 8,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic [HIST_LEN-1:0]                     ghr_i,
    input  logic                                    fetch_valid_i,
    input  logic [FETCH_WIDTH-1:0]                  lane_valid_i,
    input  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0]  pc_i,
    input  logic [FETCH_WIDTH-1:0]                  is_branch_i,
    input  logic [ENTRIES-1:0]                      ctr_msb_i,
    input  logic                                    recover_i,
    input  logic [HIST_LEN-1:0]                     recover_ghr_i,
    output logic [FETCH_WIDTH-1:0]                  taken_o,
    output logic [FETCH_WIDTH-1:0][HIST_LEN:0]      ghist_o,
    output logic [HIST_LEN-1:0]                     ghr_d_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    // Only pc bits [IDX_W+1:2] index the table.
    logic unused_pc;
    assign unused_pc = ^pc_i;

    always_comb begin
        logic [HIST_LEN-1:0]  hist;
        logic [HIST_LEN-1:0]  fetch_ghr;
        logic [MAX_IDX_W-1:0] fh;
        logic [IDX_W-1:0]     idx;
        logic                 stop;
        logic                 t;

        taken_o   = '0;
        ghist_o   = '0;
        hist      = ghr_i;
        fetch_ghr = ghr_i;
        stop      = 1'b0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            fh  = fold_hist(MAX_HIST'(hist), IDX_W);
            idx = IDX_W'(fh ^ MAX_IDX_W'(pc_i[k][IDX_W+1:2]));
            t   = is_branch_i[k] & lane_valid_i[k] & ctr_msb_i[idx];
            taken_o[k] = t;
            ghist_o[k] = {hist, t};
            if (is_branch_i[k]) begin
                hist = {hist[HIST_LEN-2:0], t};
            end
            // History commits through the first predicted-taken lane; later lanes
            // are on the wrong path.
            if (lane_valid_i[k] && !stop) begin
                fetch_ghr = hist;
                stop      = t;
            end
        end

        if (recover_i) begin
            ghr_d_o = recover_ghr_i;
        end else if (fetch_valid_i) begin
            ghr_d_o = fetch_ghr;
        end else begin
            ghr_d_o = ghr_i;
        end
    end

endmodule

// File: rtl/gshare_predictor_param.sv
// Parameterised multi-lane gshare branch predictor.
// Holds the pattern table of saturating counters and the global history
// register; resolves multiple update ports per cycle and restores history on
// a misprediction.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   fetch_valid_i       fetch bundle accepted this cycle
//   lane_valid_i        per-lane valid
//   pc_i                per-lane PC
//   is_branch_i         per-lane conditional-branch flag
//   taken_o             per-lane taken prediction (combinational)
//   ghist_o             per-lane {history used, taken_o[lane]}
//   upd_valid_i         resolve valid, port 0 oldest
//   upd_pc_i            resolved branch PC
//   upd_taken_i         actual outcome
//   upd_mispredict_i    prediction was wrong
//   upd_ghist_i         ghist_o value returned with the branch
//   recover_o           history recovery happened at the last edge
module gshare_predictor_param
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES      = 64,
    parameter int unsigned FETCH_WIDTH  = 5,
    parameter int unsigned UPDATE_PORTS = 3,
    parameter int unsigned HIST_LEN     = 8,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    fetch_valid_i,
    input  logic [FETCH_WIDTH-1:0]                  lane_valid_i,
    input  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0]  pc_i,
    input  logic [FETCH_WIDTH-1:0]                  is_branch_i,
    output logic [FETCH_WIDTH-1:0]                  taken_o,
    output logic [FETCH_WIDTH-1:0][HIST_LEN:0]      ghist_o,
    input  logic [UPDATE_PORTS-1:0]                 upd_valid_i,
    input  logic [UPDATE_PORTS-1:0][ADDR_WIDTH-1:0] upd_pc_i,
    input  logic [UPDATE_PORTS-1:0]                 upd_taken_i,
    input  logic [UPDATE_PORTS-1:0]                 upd_mispredict_i,
    input  logic [UPDATE_PORTS-1:0][HIST_LEN:0]     upd_ghist_i,
    output logic                                    recover_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [HIST_LEN-1:0] ghr_q;
    logic [HIST_LEN-1:0] ghr_d;
    logic                recover_q;

    logic [ENTRIES-1:0]  ctr_msb;
    logic [IDX_W-1:0]    upd_idx [UPDATE_PORTS];
    logic                recover;
    logic [HIST_LEN-1:0] recover_ghr;

    logic [FETCH_WIDTH-1:0]             chain_taken;
    logic [FETCH_WIDTH-1:0][HIST_LEN:0] chain_ghist;

    // Only the index bits of the PC and the history part of ghist are needed.
    logic unused_upd;
    assign unused_upd = ^{upd_pc_i, upd_ghist_i};

    for (genvar e = 0; e < ENTRIES; e++) begin : g_msb
        assign ctr_msb[e] = ctr_q[e][CTR_BITS-1];
    end

    // Update index uses the history the branch was predicted with, not the
    // prediction bit appended below it.
    for (genvar p = 0; p < UPDATE_PORTS; p++) begin : g_upd_idx
        logic [MAX_IDX_W-1:0] fh;
        assign fh         = fold_hist(MAX_HIST'(upd_ghist_i[p][HIST_LEN:1]), IDX_W);
        assign upd_idx[p] = IDX_W'(fh ^ MAX_IDX_W'(upd_pc_i[p][IDX_W+1:2]));
    end

    // Every entry folds in all matching ports in port order, so colliding
    // updates compose exactly like sequential application.
    always_comb begin
        ctr_t c;
        for (int e = 0; e < ENTRIES; e++) begin
            c = '0;
            c[CTR_BITS-1:0] = ctr_q[e];
            for (int p = 0; p < UPDATE_PORTS; p++) begin
                if (upd_valid_i[p] && (upd_idx[p] == IDX_W'(e))) begin
                    c = ctr_step(c, upd_taken_i[p], CTR_BITS);
                end
            end
            ctr_d[e] = c[CTR_BITS-1:0];
        end
    end

    // Descending scan so the oldest mispredicting port wins.
    always_comb begin
        recover     = 1'b0;
        recover_ghr = '0;
        for (int p = int'(UPDATE_PORTS) - 1; p >= 0; p--) begin
            if (upd_valid_i[p] && upd_mispredict_i[p]) begin
                recover     = 1'b1;
                recover_ghr = {upd_ghist_i[p][HIST_LEN-1:1], upd_taken_i[p]};
            end
        end
    end

    gshare_hist_chain #(
        .ENTRIES     (ENTRIES),
        .FETCH_WIDTH (FETCH_WIDTH),
        .HIST_LEN    (HIST_LEN),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_hist_chain (
        .ghr_i         (ghr_q),
        .fetch_valid_i (fetch_valid_i),
        .lane_valid_i  (lane_valid_i),
        .pc_i          (pc_i),
        .is_branch_i   (is_branch_i),
        .ctr_msb_i     (ctr_msb),
        .recover_i     (recover),
        .recover_ghr_i (recover_ghr),
        .taken_o       (chain_taken),
        .ghist_o       (chain_ghist),
        .ghr_d_o       (ghr_d)
    );

    always_comb begin
        taken_o = reset ? '0 : chain_taken;
        ghist_o = reset ? '0 : chain_ghist;
    end

    assign recover_o = recover_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                ctr_q[e] <= CTR_RESET;
            end
            ghr_q     <= '0;
            recover_q <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            ghr_q     <= ghr_d;
            recover_q <= recover;
        end
    end

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Directed bench for gshare_predictor_param at default parameters. A small
// behavioural model produces expected values that are queued on a scoreboard
// and popped when the DUT output is sampled.
module tb_gshare_predictor_param;

    localparam int FW = 5;
    localparam int UP = 3;
    localparam int HL = 8;
    localparam int AW = 32;
    localparam int NE = 64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    fetch_valid;
    logic [FW-1:0]           lane_valid;
    logic [FW-1:0][AW-1:0]   pc;
    logic [FW-1:0]           is_branch;
    logic [FW-1:0]           taken_o;
    logic [FW-1:0][HL:0]     ghist_o;
    logic [UP-1:0]           upd_valid;
    logic [UP-1:0][AW-1:0]   upd_pc;
    logic [UP-1:0]           upd_taken;
    logic [UP-1:0]           upd_mis;
    logic [UP-1:0][HL:0]     upd_ghist;
    logic                    recover_o;

    gshare_predictor_param dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid_i    (fetch_valid),
        .lane_valid_i     (lane_valid),
        .pc_i             (pc),
        .is_branch_i      (is_branch),
        .taken_o          (taken_o),
        .ghist_o          (ghist_o),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_mispredict_i (upd_mis),
        .upd_ghist_i      (upd_ghist),
        .recover_o        (recover_o)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int            ctr_m [NE];
    logic [HL-1:0] ghr_m;
    logic          rec_m;

    function automatic logic [5:0] fold_m(input logic [HL-1:0] h);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < HL; i++) r[i % 6] = r[i % 6] ^ h[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NE; e++) ctr_m[e] = 1;
        ghr_m = '0;
        rec_m = 1'b0;
    endtask

    task automatic model_fetch(output logic [FW-1:0] tk, output logic [FW-1:0][HL:0] gh,
                               output logic [HL-1:0] ng);
        logic [HL-1:0] h;
        logic [5:0]    idx;
        logic          t;
        logic          stop;
        h = ghr_m; ng = ghr_m; stop = 1'b0; tk = '0; gh = '0;
        for (int k = 0; k < FW; k++) begin
            idx   = pc[k][7:2] ^ fold_m(h);
            t     = is_branch[k] & lane_valid[k] & (ctr_m[idx] >= 2);
            tk[k] = t;
            gh[k] = {h, t};
            if (is_branch[k]) h = {h[HL-2:0], t};
            if (lane_valid[k] && !stop) begin
                ng   = h;
                stop = t;
            end
        end
    endtask

    task automatic model_edge(input logic [HL-1:0] ng);
        int         recp;
        logic [5:0] idx;
        recp = -1;
        for (int p = 0; p < UP; p++) begin
            if (upd_valid[p]) begin
                idx = upd_pc[p][7:2] ^ fold_m(upd_ghist[p][8:1]);
                if (upd_taken[p]) ctr_m[idx] = (ctr_m[idx] == 3) ? 3 : ctr_m[idx] + 1;
                else              ctr_m[idx] = (ctr_m[idx] == 0) ? 0 : ctr_m[idx] - 1;
                if (upd_mis[p] && recp < 0) recp = p;
            end
        end
        if (recp >= 0) begin
            ghr_m = {upd_ghist[recp][7:1], upd_taken[recp]};
            rec_m = 1'b1;
        end else begin
            rec_m = 1'b0;
            if (fetch_valid) ghr_m = ng;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic check_const(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        fetch_valid = 1'b0; lane_valid = '0; pc = '0; is_branch = '0;
        upd_valid = '0; upd_pc = '0; upd_taken = '0; upd_mis = '0; upd_ghist = '0;
    endtask

    task automatic lane(input int k, input logic [31:0] a, input logic br);
        lane_valid[k] = 1'b1;
        pc[k]         = a;
        is_branch[k]  = br;
    endtask

    task automatic upd(input int p, input logic [31:0] a, input logic tk, input logic mis,
                       input logic [8:0] gh);
        upd_valid[p] = 1'b1;
        upd_pc[p]    = a;
        upd_taken[p] = tk;
        upd_mis[p]   = mis;
        upd_ghist[p] = gh;
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic cycle(input string tag);
        logic [FW-1:0]       tk;
        logic [FW-1:0][HL:0] gh;
        logic [HL-1:0]       ng;
        #1;
        model_fetch(tk, gh, ng);
        sb_push({tag, "/taken"}, 64'(tk));
        sb_check(64'(taken_o));
        sb_push({tag, "/ghist"}, 64'(gh));
        sb_check(64'(ghist_o));
        @(posedge clk);
        model_edge(ng);
        #1;
        sb_push({tag, "/recover"}, 64'(rec_m));
        sb_check(64'(recover_o));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        // Outputs held at zero while reset is high, whatever the inputs.
        fetch_valid = 1'b1;
        lane(0, 32'h40, 1'b1);
        upd(0, 32'h40, 1'b1, 1'b1, 9'h1ff);
        #1;
        check_const("rst_taken", 64'(taken_o), 64'h0);
        check_const("rst_ghist", 64'(ghist_o), 64'h0);
        check_const("rst_recover", 64'(recover_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();

        // Lane-0 branch at 0x40 right after reset.
        lane(0, 32'h40, 1'b1);
        #1;
        check_const("r038_taken0", 64'(taken_o[0]), 64'h0);
        check_const("r038_ghist0", 64'(ghist_o[0]), 64'h0);
        cycle("r038");

        // Counter 33 driven to 0, then four taken updates: 1,2,3,3.
        idle();
        upd(0, 32'h84, 1'b0, 1'b0, 9'h0);
        cycle("r039_pre");
        for (int i = 0; i < 4; i++) begin
            idle();
            upd(0, 32'h84, 1'b1, 1'b0, 9'h0);
            lane(0, 32'h84, 1'b1);
            #1;
            check_const("r039_flip", 64'(taken_o[0]), (i >= 2) ? 64'h1 : 64'h0);
            cycle("r039_inc");
        end
        // Saturated at 3: two decrements still leave it taken until the second lands.
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i < 2) upd(0, 32'h84, 1'b0, 1'b0, 9'h0);
            lane(0, 32'h84, 1'b1);
            #1;
            check_const("r039_sat", 64'(taken_o[0]), (i < 2) ? 64'h1 : 64'h0);
            cycle("r039_dec");
        end

        // Two ports, same index, taken then not-taken, from counter 1.
        idle();
        upd(0, 32'h0c, 1'b1, 1'b0, 9'h0);
        upd(1, 32'h0c, 1'b0, 1'b0, 9'h0);
        cycle("r040_collide");
        idle();
        lane(0, 32'h0c, 1'b1);
        upd(0, 32'h0c, 1'b1, 1'b0, 9'h0);
        #1;
        check_const("r040_after", 64'(taken_o[0]), 64'h0);
        cycle("r040_probe");
        idle();
        lane(0, 32'h0c, 1'b1);
        #1;
        check_const("r040_plus1", 64'(taken_o[0]), 64'h1);
        cycle("r040_final");

        // Ports 1 and 2 mispredict together while fetching.
        idle();
        fetch_valid = 1'b1;
        lane(0, 32'h40, 1'b1);
        upd(0, 32'h100, 1'b1, 1'b0, 9'h0);
        upd(1, 32'h104, 1'b1, 1'b1, 9'h13c);
        upd(2, 32'h108, 1'b0, 1'b1, 9'h0ff);
        cycle("r041_recover");
        idle();
        #1;
        check_const("r041_ghr", 64'(ghist_o[0][HL:1]), 64'h3d);
        check_const("r041_rec", 64'(recover_o), 64'h1);
        cycle("r041_after");

        // Train index 2 taken and restore ghr to 0.
        idle();
        upd(0, 32'h208, 1'b1, 1'b0, 9'h0);
        upd(1, 32'h300, 1'b0, 1'b1, 9'h0);
        cycle("r042_setup");
        // Lane 1 taken ends the bundle; lane 3 must not contribute.
        idle();
        fetch_valid = 1'b1;
        lane(0, 32'h200, 1'b0);
        lane(1, 32'h208, 1'b1);
        lane(2, 32'h20c, 1'b0);
        lane(3, 32'h210, 1'b1);
        #1;
        check_const("r042_taken", 64'(taken_o), 64'h02);
        cycle("r042_bundle");
        idle();
        #1;
        check_const("r042_ghr", 64'(ghist_o[0][HL:1]), 64'h01);
        cycle("r042_after");
        // No taken lane: shift through the last valid lane, non-branches skipped.
        idle();
        fetch_valid = 1'b1;
        lane(0, 32'h10, 1'b0);
        lane(1, 32'h14, 1'b1);
        lane(2, 32'h18, 1'b1);
        cycle("nt_bundle");
        idle();
        #1;
        check_const("nt_ghr", 64'(ghist_o[0][HL:1]), 64'h04);
        cycle("nt_after");

        // History wider than the index: fold wraps bits 7:6 onto the index.
        idle();
        upd(0, 32'h600, 1'b1, 1'b1, 9'h0c0);
        cycle("fold_setghr");
        idle();
        upd(0, 32'h530, 1'b1, 1'b0, 9'h182);
        upd(1, 32'h530, 1'b1, 1'b0, 9'h182);
        cycle("fold_train");
        idle();
        lane(0, 32'h530, 1'b1);
        #1;
        check_const("fold_ghr", 64'(ghist_o[0][HL:1]), 64'hc1);
        check_const("fold_taken", 64'(taken_o[0]), 64'h1);
        cycle("fold_probe");

        // ghr = 0xA5, then reset lands in the middle of a bundle with an update.
        idle();
        upd(0, 32'h400, 1'b1, 1'b1, 9'h0a4);
        cycle("r043_set");
        idle();
        #1;
        check_const("r043_ghr_a5", 64'(ghist_o[0][HL:1]), 64'ha5);
        cycle("r043_hold");
        idle();
        fetch_valid = 1'b1;
        lane(0, 32'h40, 1'b1);
        upd(0, 32'h208, 1'b0, 1'b1, 9'h0);
        #2;
        reset = 1'b1;
        #1;
        check_const("r043_rst_taken", 64'(taken_o), 64'h0);
        check_const("r043_rst_ghist", 64'(ghist_o), 64'h0);
        @(posedge clk);
        #1;
        check_const("r043_rst_rec", 64'(recover_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle();
        #1;
        check_const("r043_ghr0", 64'(ghist_o[0][HL:1]), 64'h0);
        // Index 2 was at 2 before reset: now weakly not-taken and the dropped
        // not-taken update must not have landed.
        lane(0, 32'h208, 1'b1);
        upd(0, 32'h208, 1'b1, 1'b0, 9'h0);
        #1;
        check_const("r043_ctr_init", 64'(taken_o[0]), 64'h0);
        cycle("r043_first");
        idle();
        lane(0, 32'h208, 1'b1);
        lane(1, 32'h84, 1'b0);
        #1;
        check_const("r043_no_drop", 64'(taken_o[0]), 64'h1);
        cycle("r043_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
